decode_issue: RTL and testbench
===============================

# decode_issue

Second pipeline stage. It takes the registered 64-bit two-instruction bundle and bundle PC from fetch and serialises the bundle into one instruction per cycle for execute. It also inserts a one-cycle bubble on load-use hazards and drives `interlock` back to fetch so that fetch holds its outputs while a bundle is still being drained.

## Interface
Parameters:
- `LOAD_USE_BUBBLES`, default 1: bubbles inserted after a `Load` whose `rd` is read by the next issued instruction. Only 1 is supported.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `pc_in`  in  32: bundle PC from fetch. Counts bundles.
- `inst_in`  in  64: bundle from fetch. Slot0 = `[63:32]`, slot1 = `[31:0]`.
- `flush`  in  1: branch taken in execute; same signal as fetch's `branch_flag`.
- `ex_stall`  in  1: execute cannot accept an instruction this cycle.
- `interlock`  out  1: combinational. 1 = fetch must hold `pc_in`/`inst_in`.
- `issue_inst`  out  32: registered instruction to execute.
- `issue_pc`  out  32: registered bundle PC of `issue_inst`.
- `issue_slot`  out  1: registered slot index of `issue_inst` (0 or 1).
- `issue_rd`, `issue_rs1`, `issue_rs2`  out  5 each: registered fields `[25:21]`, `[20:16]`, `[15:11]` of `issue_inst`.
- `issue_is_load`  out  1: registered. 1 when `issue_inst[31:26]` == `Load`.

## Operation
- NOP means a word with `[31:26] == Nop` and the rest 0. Opcodes `Nop` and `Load` come from `inst_package`.
- State `sel` has two values:
  - `S0`: slot0 of the current `inst_in` is pending.
  - `S1`: slot0 is done and slot1 is pending.
- Candidate instruction (`cand`):
  - In `S0`: slot0, unless slot0 is NOP and slot1 is not NOP, in which case slot1 (skip).
  - In `S1`: slot1.
- Hazard: `last_load` is registered and equals `issue_is_load`. A hazard exists when `last_load`, `issue_rd != 0`, and (`cand.rs1 == issue_rd` or `cand.rs2 == issue_rd`). Both source fields are always compared, conservatively, regardless of opcode.
- Per-cycle priority, highest first:
  1. `~rstn`: all outputs go to reset values, `sel ← S0`.
  2. `flush`: issue NOP, `sel ← S0`, `interlock = 0`. The current bundle is discarded; fetch already delivers a NOP bundle.
  3. `ex_stall`: all issue registers hold, `sel` holds, `interlock = 1`.
  4. Hazard: issue NOP (this clears `last_load`), `sel` holds, `interlock = 1`.
  5. Otherwise: issue `cand`, then:
     - If `cand` is slot0 and slot1 is not NOP: `sel ← S1`, `interlock = 1`.
     - Else: `sel ← S0`, `interlock = 0` (bundle consumed).
- An all-NOP bundle issues one NOP (slot0) with `interlock = 0`.
- `issue_pc`/`issue_slot` track `cand` even for NOP issues. Bubbles and flushes set `issue_pc = 0`, `issue_slot = 0`.
- Reset values: `issue_inst = {Nop, 26'b0}`, `issue_pc = 0`, `issue_slot = 0`, `issue_rd`/`rs1`/`rs2` = 0, `issue_is_load = 0`, `sel = S0`, `interlock = 0` while `rstn` is low.

## Timing
- Latency is 1 cycle: `cand` selected in cycle N appears on `issue_*` after edge N.
- Throughput:
  - Bundle with two non-NOP slots: 2 cycles, `interlock` high in the first.
  - Bundle with one non-NOP slot: 1 cycle.
  - Each load-use hazard adds 1 cycle.
- `interlock` is a pure function of `sel`, `inst_in`, `issue_*`, `flush`, `ex_stall`, `rstn`. It has no path from `pc_in`. Fetch samples it at the same edge.
- `flush` together with `ex_stall`: `flush` wins. The NOP is written even though execute is stalled.
- `flush` in `S1`: slot1 is dropped and `sel ← S0` at the edge.
- Reset mid-bundle: `sel ← S0` at the edge. The bundle is abandoned and fetch restarts from PC 0.
- A hazard in `S1` holds `S1`. Slot1 issues the next cycle, then `interlock` drops.

## Test plan
- Reset: hold `rstn = 0` for 2 cycles with random `inst_in` -> all `issue_*` at reset values, `issue_inst = {Nop, 0}`, `interlock = 0`.
- Full bundle, `pc_in = 5`, slot0 = ADD r3, slot1 = SUB r4 -> cycle 1: `interlock = 1`, issue slot0 `(pc 5, slot 0)`; cycle 2: `interlock = 0`, issue slot1 `(pc 5, slot 1)`.
- Slot0 NOP, slot1 = ADD r7, r1, r2 -> single cycle, issue slot1 `(slot 1)`, `interlock = 0`. Bundle of two NOPs -> one NOP issued, `interlock = 0`.
- Load-use: slot0 = `Load` r5, slot1 reads `rs1 = 5` -> slot0 issued, then NOP bubble with `interlock = 1`, then slot1. Repeat with rd = r0 -> no bubble.
- `ex_stall = 1` for 3 cycles in `S1` -> `issue_*` frozen, `interlock = 1` throughout; slot1 issues on the cycle after the stall drops.
- `flush` asserted in `S1` while `ex_stall = 1` -> NOP issued, `sel = S0`, `interlock = 0`; next bundle's slot0 issues normally.

Source files
------------

// File: rtl/inst_package.sv
// Instruction-set constants shared by the pipeline stages.
package inst_package;

  localparam logic [5:0] Nop  = 6'h00;
  localparam logic [5:0] Load = 6'h23;

endpackage

// File: rtl/decode_issue.sv
// Decode/issue stage: serialises a two-slot fetch bundle into one instruction
// per cycle, inserts load-use bubbles and back-pressures fetch via interlock.
module decode_issue
  import inst_package::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_in,
  input  logic [63:0] inst_in,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        interlock,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  output logic        issue_slot,
  output logic [4:0]  issue_rd,
  output logic [4:0]  issue_rs1,
  output logic [4:0]  issue_rs2,
  output logic        issue_is_load
);

  localparam logic [31:0] NOP_WORD = {Nop, 26'd0};

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } sel_t;

  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FLUSH  = 3'd1,
    ACT_HOLD   = 3'd2,
    ACT_BUBBLE = 3'd3,
    ACT_ISSUE  = 3'd4
  } act_t;

  function automatic logic is_nop(input logic [31:0] w);
    return w == NOP_WORD;
  endfunction

  sel_t        sel_r;
  sel_t        sel_next_s;
  act_t        act_s;
  logic [31:0] slot0_s;
  logic [31:0] slot1_s;
  logic [31:0] cand_s;
  logic        slot0_nop_s;
  logic        slot1_nop_s;
  logic        cand_slot1_s;
  logic        hazard_s;

  // Candidate selection and load-use hazard detection.
  always_comb begin
    slot0_s      = inst_in[63:32];
    slot1_s      = inst_in[31:0];
    slot0_nop_s  = is_nop(slot0_s);
    slot1_nop_s  = is_nop(slot1_s);
    // A NOP in slot0 is skipped when slot1 carries real work.
    cand_slot1_s = (sel_r == S1) || (slot0_nop_s && !slot1_nop_s);
    if (cand_slot1_s) begin
      cand_s = slot1_s;
    end else begin
      cand_s = slot0_s;
    end
    // Both source fields are compared regardless of opcode (conservative).
    hazard_s = (LOAD_USE_BUBBLES > 0) && issue_is_load && (issue_rd != 5'd0) &&
               ((cand_s[20:16] == issue_rd) || (cand_s[15:11] == issue_rd));
  end

  // Per-cycle action priority, next slot pointer and fetch interlock.
  always_comb begin
    act_s      = ACT_ISSUE;
    sel_next_s = S0;
    interlock  = 1'b0;
    if (!rstn) begin
      act_s = ACT_RESET;
    end else if (flush) begin
      act_s = ACT_FLUSH;
    end else if (ex_stall) begin
      act_s      = ACT_HOLD;
      sel_next_s = sel_r;
      interlock  = 1'b1;
    end else if (hazard_s) begin
      act_s      = ACT_BUBBLE;
      sel_next_s = sel_r;
      interlock  = 1'b1;
    end else if (!cand_slot1_s && !slot1_nop_s) begin
      act_s      = ACT_ISSUE;
      sel_next_s = S1;
      interlock  = 1'b1;
    end else begin
      act_s      = ACT_ISSUE;
      sel_next_s = S0;
      interlock  = 1'b0;
    end
  end

  // Slot pointer and issue registers.
  always_ff @(posedge clk) begin
    sel_r <= sel_next_s;
    case (act_s)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        issue_inst    <= NOP_WORD;
        issue_pc      <= 32'd0;
        issue_slot    <= 1'b0;
        issue_rd      <= 5'd0;
        issue_rs1     <= 5'd0;
        issue_rs2     <= 5'd0;
        issue_is_load <= 1'b0;
      end
      ACT_ISSUE: begin
        issue_inst    <= cand_s;
        issue_pc      <= pc_in;
        issue_slot    <= cand_slot1_s;
        issue_rd      <= cand_s[25:21];
        issue_rs1     <= cand_s[20:16];
        issue_rs2     <= cand_s[15:11];
        issue_is_load <= (cand_s[31:26] == Load);
      end
      default: begin
        issue_inst    <= issue_inst;
        issue_pc      <= issue_pc;
        issue_slot    <= issue_slot;
        issue_rd      <= issue_rd;
        issue_rs1     <= issue_rs1;
        issue_rs2     <= issue_rs2;
        issue_is_load <= issue_is_load;
      end
    endcase
  end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios plus a randomized
// run against a queue-based bundle model.
module tb_decode_issue;
  import inst_package::*;

  localparam logic [5:0]  ADD_OP = 6'h01;
  localparam logic [5:0]  SUB_OP = 6'h02;
  localparam logic [31:0] NOP_W  = {Nop, 26'd0};

  logic        clk = 1'b0;
  logic        rstn, flush, ex_stall;
  logic [31:0] pc_in;
  logic [63:0] inst_in;
  logic        interlock;
  logic [31:0] issue_inst, issue_pc;
  logic        issue_slot, issue_is_load;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic il_s;

  typedef struct packed {
    logic [31:0] w;
    logic        s;
  } item_t;
  item_t q[$];

  decode_issue #(.LOAD_USE_BUBBLES(1)) dut (
    .clk(clk), .rstn(rstn), .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
    .ex_stall(ex_stall), .interlock(interlock), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .issue_slot(issue_slot), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_is_load(issue_is_load)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  // Expected issue tuple for word w at (pc, slot), fields taken from the word.
  function automatic logic [80:0] exp_of(input logic [31:0] w, input logic [31:0] pc,
                                         input logic s);
    return {w, pc, s, w[25:21], w[20:16], w[15:11], (w[31:26] == Load)};
  endfunction

  function automatic logic [80:0] got_v();
    return {issue_inst, issue_pc, issue_slot, issue_rd, issue_rs1, issue_rs2, issue_is_load};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [4:0] rd, r1, r2;
    rd = 5'($urandom_range(3));
    r1 = 5'($urandom_range(3));
    r2 = 5'($urandom_range(3));
    case ($urandom_range(3))
      0:       return NOP_W;
      1:       return mk(Load, rd, r1, r2);
      2:       return mk(ADD_OP, rd, r1, r2);
      default: return mk(SUB_OP, rd, r1, r2);
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    il_s = interlock;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    inst_in = {$urandom, $urandom}; pc_in = $urandom;
    tick();
    inst_in = {$urandom, $urandom};
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL reset_il got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(NOP_W, 32'd0, 1'b0)) begin
      n_bad++; $display("FAIL reset_issue got %h want %h", got_v(), exp_of(NOP_W, 32'd0, 1'b0));
    end
    rstn = 1'b1;
  endtask

  task automatic test_full_bundle();
    logic [31:0] a, b;
    a = mk(ADD_OP, 5'd3, 5'd1, 5'd2);
    b = mk(SUB_OP, 5'd4, 5'd1, 5'd2);
    pc_in = 32'd5; inst_in = {a, b};
    tick();
    n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL full_il0 got %b want 1", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(a, 32'd5, 1'b0)) begin
      n_bad++; $display("FAIL full_slot0 got %h want %h", got_v(), exp_of(a, 32'd5, 1'b0));
    end
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL full_il1 got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(b, 32'd5, 1'b1)) begin
      n_bad++; $display("FAIL full_slot1 got %h want %h", got_v(), exp_of(b, 32'd5, 1'b1));
    end
  endtask

  task automatic test_skip_nop();
    logic [31:0] a;
    a = mk(ADD_OP, 5'd7, 5'd1, 5'd2);
    pc_in = 32'd7; inst_in = {NOP_W, a};
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL skip_il got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(a, 32'd7, 1'b1)) begin
      n_bad++; $display("FAIL skip_issue got %h want %h", got_v(), exp_of(a, 32'd7, 1'b1));
    end
    pc_in = 32'd8; inst_in = {NOP_W, NOP_W};
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL nopnop_il got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(NOP_W, 32'd8, 1'b0)) begin
      n_bad++; $display("FAIL nopnop_issue got %h want %h", got_v(), exp_of(NOP_W, 32'd8, 1'b0));
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ld, us;
    ld = mk(Load, 5'd5, 5'd1, 5'd0);
    us = mk(ADD_OP, 5'd6, 5'd5, 5'd2);
    pc_in = 32'd9; inst_in = {ld, us};
    tick();
    n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL lu_il0 got %b want 1", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(ld, 32'd9, 1'b0)) begin
      n_bad++; $display("FAIL lu_load got %h want %h", got_v(), exp_of(ld, 32'd9, 1'b0));
    end
    tick();
    n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL lu_il1 got %b want 1", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(NOP_W, 32'd0, 1'b0)) begin
      n_bad++; $display("FAIL lu_bubble got %h want %h", got_v(), exp_of(NOP_W, 32'd0, 1'b0));
    end
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL lu_il2 got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(us, 32'd9, 1'b1)) begin
      n_bad++; $display("FAIL lu_use got %h want %h", got_v(), exp_of(us, 32'd9, 1'b1));
    end
    // Load to r0 never creates a hazard.
    ld = mk(Load, 5'd0, 5'd1, 5'd0);
    us = mk(ADD_OP, 5'd6, 5'd0, 5'd2);
    pc_in = 32'd10; inst_in = {ld, us};
    tick();
    n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL lu0_il0 got %b want 1", il_s); end
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL lu0_il1 got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(us, 32'd10, 1'b1)) begin
      n_bad++; $display("FAIL lu0_use got %h want %h", got_v(), exp_of(us, 32'd10, 1'b1));
    end
  endtask

  task automatic test_stall_s1();
    logic [31:0] a, b;
    a = mk(ADD_OP, 5'd3, 5'd1, 5'd2);
    b = mk(SUB_OP, 5'd4, 5'd1, 5'd2);
    pc_in = 32'd11; inst_in = {a, b};
    tick();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL stall_il[%0d] got %b want 1", i, il_s); end
      n_cmp++;
      if (got_v() !== exp_of(a, 32'd11, 1'b0)) begin
        n_bad++; $display("FAIL stall_hold[%0d] got %h want %h", i, got_v(), exp_of(a, 32'd11, 1'b0));
      end
    end
    ex_stall = 1'b0;
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL stall_rel_il got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(b, 32'd11, 1'b1)) begin
      n_bad++; $display("FAIL stall_rel got %h want %h", got_v(), exp_of(b, 32'd11, 1'b1));
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] a, b;
    a = mk(ADD_OP, 5'd3, 5'd1, 5'd2);
    b = mk(SUB_OP, 5'd4, 5'd1, 5'd2);
    pc_in = 32'd12; inst_in = {a, b};
    tick();
    flush = 1'b1; ex_stall = 1'b1;
    tick();
    n_cmp++; if (il_s !== 1'b0) begin n_bad++; $display("FAIL flush_il got %b want 0", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(NOP_W, 32'd0, 1'b0)) begin
      n_bad++; $display("FAIL flush_nop got %h want %h", got_v(), exp_of(NOP_W, 32'd0, 1'b0));
    end
    flush = 1'b0; ex_stall = 1'b0;
    pc_in = 32'd13; inst_in = {b, a};
    tick();
    n_cmp++; if (il_s !== 1'b1) begin n_bad++; $display("FAIL post_flush_il got %b want 1", il_s); end
    n_cmp++;
    if (got_v() !== exp_of(b, 32'd13, 1'b0)) begin
      n_bad++; $display("FAIL post_flush_s0 got %h want %h", got_v(), exp_of(b, 32'd13, 1'b0));
    end
    tick();
    n_cmp++;
    if (got_v() !== exp_of(a, 32'd13, 1'b1)) begin
      n_bad++; $display("FAIL post_flush_s1 got %h want %h", got_v(), exp_of(a, 32'd13, 1'b1));
    end
  endtask

  // Model: each accepted bundle becomes a queue of instructions to issue.
  task automatic test_random();
    logic [80:0] exp_v;
    logic [31:0] last_w, pc_cnt;
    logic        exp_il, prev_il, hz;
    exp_v = exp_of(NOP_W, 32'd0, 1'b0); prev_il = 1'b0; pc_cnt = 32'd0; q.delete();
    rstn = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    inst_in = {rand_word(), rand_word()}; pc_in = 32'd0;
    tick();
    for (int c = 0; c < 800; c++) begin
      rstn     = ($urandom_range(99) != 0);
      flush    = ($urandom_range(19) == 0);
      ex_stall = ($urandom_range(6) == 0);
      if (!prev_il) begin
        inst_in = {rand_word(), rand_word()};
        pc_cnt  = pc_cnt + 32'd1;
        pc_in   = pc_cnt;
      end
      if (!rstn) begin
        q.delete(); exp_v = exp_of(NOP_W, 32'd0, 1'b0); exp_il = 1'b0; pc_cnt = 32'd0;
      end else if (flush) begin
        q.delete(); exp_v = exp_of(NOP_W, 32'd0, 1'b0); exp_il = 1'b0;
      end else begin
        if (q.size() == 0) begin
          if (inst_in[63:32] != NOP_W) q.push_back('{w: inst_in[63:32], s: 1'b0});
          if (inst_in[31:0] != NOP_W)  q.push_back('{w: inst_in[31:0], s: 1'b1});
          if (q.size() == 0)           q.push_back('{w: inst_in[63:32], s: 1'b0});
        end
        last_w = exp_v[80:49];
        hz = (last_w[31:26] == Load) && (last_w[25:21] != 5'd0) &&
             ((q[0].w[20:16] == last_w[25:21]) || (q[0].w[15:11] == last_w[25:21]));
        if (ex_stall) begin
          exp_il = 1'b1;
        end else if (hz) begin
          exp_v = exp_of(NOP_W, 32'd0, 1'b0); exp_il = 1'b1;
        end else begin
          exp_v = exp_of(q[0].w, pc_in, q[0].s);
          void'(q.pop_front());
          exp_il = (q.size() != 0);
        end
      end
      tick();
      n_cmp++;
      if (il_s !== exp_il) begin
        n_bad++; $display("FAIL rand_il[%0d] got %b want %b", c, il_s, exp_il);
      end
      n_cmp++;
      if (got_v() !== exp_v) begin
        n_bad++; $display("FAIL rand_issue[%0d] got %h want %h", c, got_v(), exp_v);
      end
      prev_il = exp_il;
    end
    rstn = 1'b1; flush = 1'b0; ex_stall = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; ex_stall = 1'b0; pc_in = 32'd0; inst_in = 64'd0;
    test_reset();
    test_full_bundle();
    test_skip_nop();
    test_load_use();
    test_stall_s1();
    test_flush_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
